// File: rtl/prio_encoder_8to3_hs_pkg.sv
// Shared widths, FSM state encoding and the 3-to-8 one-hot mapping used by
// the priority encoder and its bench.
package prio_encoder_8to3_hs_pkg;

  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Same mapping as the companion 3-to-8 decoder.
  function automatic logic [REQ_W-1:0] one_hot3(input logic [CODE_W-1:0] code);
    logic [REQ_W-1:0] mask;
    mask = '0;
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/prio_encoder_8to3_hs_if.sv
// Request/acknowledge bundle for the 8-to-3 priority encoder.
// Handshake: a code transfers on a rising clk edge where valid && ready; while
// valid=1 and ready=0, code and valid hold stable; ready with valid=0 is ignored.
interface prio_encoder_8to3_hs_if;
  import prio_encoder_8to3_hs_pkg::*;

  logic [REQ_W-1:0]  req;
  logic              ready;
  logic              clr_ovf;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic [REQ_W-1:0]  pend;
  logic              ovf;
  state_t            state;

  modport master (
    output req, ready, clr_ovf,
    input  code, valid, pend, ovf, state
  );

  modport slave (
    input  req, ready, clr_ovf,
    output code, valid, pend, ovf, state
  );

endinterface

// File: rtl/prio_encoder_8to3_hs_prio_enc8.sv
// Combinational 8-bit priority encoder; HIGH_FIRST selects whether bit 7 or
// bit 0 wins.
module prio_enc8 #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [7:0] vec,
  output logic [2:0] code,
  output logic       any
);

  always_comb begin
    code = 3'd0;
    any  = |vec;
    // The last matching index in loop order wins.
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (vec[i]) code = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (vec[i]) code = 3'(i);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_8to3_hs.sv
// Registered 8-to-3 priority encoder: captures requests into a pending set and
// offers the winning index on a valid/ready handshake that retires it.
module prio_encoder_8to3_hs
  import prio_encoder_8to3_hs_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  prio_encoder_8to3_hs_if.slave bus
);

  state_t            state_q;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic [REQ_W-1:0]  pend_q;
  logic              ovf_q;

  logic [REQ_W-1:0]  clr_mask;
  logic [REQ_W-1:0]  vec;
  logic [CODE_W-1:0] sel;
  logic              any;
  logic              overrun;

  always_comb begin
    clr_mask = '0;
    if (valid_q && bus.ready) clr_mask = one_hot3(code_q);
  end

  // OR-ing req after the clear lets a same-cycle request keep its bit pending.
  assign vec     = (pend_q & ~clr_mask) | bus.req;
  assign overrun = |(bus.req & pend_q & ~clr_mask);

  prio_enc8 #(.HIGH_FIRST(HIGH_FIRST)) u_enc (
    .vec  (vec),
    .code (sel),
    .any  (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q <= vec;
      if (overrun)          ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (any) begin
            code_q  <= sel;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          // No preemption: the offered code only changes after acceptance.
          if (bus.ready) begin
            if (any) begin
              code_q <= sel;
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.code  = code_q;
  assign bus.valid = valid_q;
  assign bus.pend  = pend_q;
  assign bus.ovf   = ovf_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_prio_encoder_8to3_hs.sv
// Bench for prio_encoder_8to3_hs: two instances (bit 7 first / bit 0 first)
// driven in lockstep and compared against a per-instance reference model.
module tb_prio_encoder_8to3_hs;
  import prio_encoder_8to3_hs_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prio_encoder_8to3_hs_if hi_if ();
  prio_encoder_8to3_hs_if lo_if ();

  prio_encoder_8to3_hs #(.HIGH_FIRST(1'b1)) dut_hi (.clk(clk), .rst(rst), .bus(hi_if));
  prio_encoder_8to3_hs #(.HIGH_FIRST(1'b0)) dut_lo (.clk(clk), .rst(rst), .bus(lo_if));

  logic [7:0] enc_in;
  logic [2:0] enc_hi_code, enc_lo_code;
  logic       enc_hi_any, enc_lo_any;
  prio_enc8 #(.HIGH_FIRST(1'b1)) enc_hi (.vec(enc_in), .code(enc_hi_code), .any(enc_hi_any));
  prio_enc8 #(.HIGH_FIRST(1'b0)) enc_lo (.vec(enc_in), .code(enc_lo_code), .any(enc_lo_any));

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // index 0 models the HIGH_FIRST=1 instance, index 1 the HIGH_FIRST=0 one
  logic [7:0] m_pend[2];
  logic [2:0] m_code[2];
  logic       m_valid[2];
  logic       m_ovf[2];

  function automatic logic [2:0] pick(input logic [7:0] v, input bit high_first);
    logic [2:0] r;
    r = 3'd0;
    if (high_first) begin
      for (int i = 7; i >= 0; i--) if (v[i]) begin r = 3'(i); break; end
    end else begin
      for (int i = 0; i < 8; i++) if (v[i]) begin r = 3'(i); break; end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 8'h00; m_code[d] = 3'd0; m_valid[d] = 1'b0; m_ovf[d] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic rd, input logic c);
    for (int d = 0; d < 2; d++) begin
      logic       taken;
      logic [7:0] retired, left;
      logic       hit;
      taken   = m_valid[d] && rd;
      retired = taken ? one_hot3(m_code[d]) : 8'h00;
      hit     = ((r & m_pend[d] & ~retired) != 8'h00);
      left    = (m_pend[d] & ~retired) | r;
      if (!m_valid[d] || taken) begin
        m_valid[d] = (left != 8'h00);
        if (left != 8'h00) m_code[d] = pick(left, d == 0);
      end
      m_pend[d] = left;
      if (hit) m_ovf[d] = 1'b1;
      else if (c) m_ovf[d] = 1'b0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".hi.valid"}, 32'(hi_if.valid), 32'(m_valid[0]));
    check({tag, ".hi.code"},  32'(hi_if.code),  32'(m_code[0]));
    check({tag, ".hi.pend"},  32'(hi_if.pend),  32'(m_pend[0]));
    check({tag, ".hi.ovf"},   32'(hi_if.ovf),   32'(m_ovf[0]));
    check({tag, ".hi.state"}, 32'(hi_if.state), 32'(m_valid[0] ? OFFER : IDLE));
    check({tag, ".lo.valid"}, 32'(lo_if.valid), 32'(m_valid[1]));
    check({tag, ".lo.code"},  32'(lo_if.code),  32'(m_code[1]));
    check({tag, ".lo.pend"},  32'(lo_if.pend),  32'(m_pend[1]));
    check({tag, ".lo.ovf"},   32'(lo_if.ovf),   32'(m_ovf[1]));
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic [7:0] r, input logic rd, input logic c);
    hi_if.req = r; hi_if.ready = rd; hi_if.clr_ovf = c;
    lo_if.req = r; lo_if.ready = rd; lo_if.clr_ovf = c;
    @(posedge clk);
    model_step(r, rd, c);
    #1;
    check_model(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    hi_if.req = 8'h00; hi_if.ready = 1'b0; hi_if.clr_ovf = 1'b0;
    lo_if.req = 8'h00; lo_if.ready = 1'b0; lo_if.clr_ovf = 1'b0;
    enc_in = 8'h00;
    model_reset();

    // exhaustive combinational encoder check
    for (int v = 0; v < 256; v++) begin
      enc_in = 8'(v);
      #1;
      check("enc_hi.code", 32'(enc_hi_code), 32'(pick(8'(v), 1'b1)));
      check("enc_hi.any",  32'(enc_hi_any),  32'(v != 0));
      check("enc_lo.code", 32'(enc_lo_code), 32'(pick(8'(v), 1'b0)));
      check("enc_lo.any",  32'(enc_lo_any),  32'(v != 0));
    end

    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk) rst = 1'b0;

    // single request, held offer
    step("req04", 8'h04, 1'b0, 1'b0);
    check("req04.code", 32'(hi_if.code), 32'd2);
    check("req04.valid", 32'(hi_if.valid), 32'd1);
    check("req04.pend", 32'(hi_if.pend), 32'h04);
    for (int i = 0; i < 5; i++) begin
      step("hold", 8'h00, 1'b0, 1'b0);
      check("hold.code", 32'(hi_if.code), 32'd2);
    end

    // no preemption, then two acceptances
    step("req80", 8'h80, 1'b0, 1'b0);
    check("req80.code", 32'(hi_if.code), 32'd2);
    check("req80.pend", 32'(hi_if.pend), 32'h84);
    step("acc2", 8'h00, 1'b1, 1'b0);
    check("acc2.code", 32'(hi_if.code), 32'd7);
    check("acc2.pend", 32'(hi_if.pend), 32'h80);
    step("acc7", 8'h00, 1'b1, 1'b0);
    check("acc7.valid", 32'(hi_if.valid), 32'd0);
    check("acc7.pend", 32'(hi_if.pend), 32'h00);

    // back-to-back burst in both priority orders
    step("burst", 8'hFF, 1'b1, 1'b0);
    check("burst.hi.code", 32'(hi_if.code), 32'd7);
    check("burst.lo.code", 32'(lo_if.code), 32'd0);
    for (int j = 1; j < 8; j++) begin
      step("burst_n", 8'h00, 1'b1, 1'b0);
      check("burst_n.hi.code", 32'(hi_if.code), 32'(7 - j));
      check("burst_n.lo.code", 32'(lo_if.code), 32'(j));
      check("burst_n.hi.valid", 32'(hi_if.valid), 32'd1);
    end
    step("burst_end", 8'h00, 1'b1, 1'b0);
    check("burst_end.hi.valid", 32'(hi_if.valid), 32'd0);
    check("burst_end.lo.valid", 32'(lo_if.valid), 32'd0);

    // overrun and its clear
    step("ovf_a", 8'h08, 1'b0, 1'b0);
    check("ovf_a.code", 32'(hi_if.code), 32'd3);
    check("ovf_a.ovf", 32'(hi_if.ovf), 32'd0);
    step("ovf_b", 8'h08, 1'b0, 1'b0);
    check("ovf_b.ovf", 32'(hi_if.ovf), 32'd1);
    step("ovf_clr", 8'h00, 1'b0, 1'b1);
    check("ovf_clr.ovf", 32'(hi_if.ovf), 32'd0);
    step("ovf_win", 8'h08, 1'b0, 1'b1);
    check("ovf_win.ovf", 32'(hi_if.ovf), 32'd1);
    step("ovf_drain", 8'h00, 1'b1, 1'b1);
    check("ovf_drain.valid", 32'(hi_if.valid), 32'd0);

    // same-cycle set and clear
    step("sc_a", 8'h20, 1'b0, 1'b0);
    check("sc_a.code", 32'(hi_if.code), 32'd5);
    step("sc_b", 8'h20, 1'b1, 1'b0);
    check("sc_b.code", 32'(hi_if.code), 32'd5);
    check("sc_b.valid", 32'(hi_if.valid), 32'd1);
    check("sc_b.pend", 32'(hi_if.pend), 32'h20);
    check("sc_b.ovf", 32'(hi_if.ovf), 32'd0);
    step("sc_drain", 8'h00, 1'b1, 1'b0);

    // asynchronous reset between edges
    step("ar_load", 8'hA0, 1'b0, 1'b0);
    check("ar_load.pend", 32'(hi_if.pend), 32'hA0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("ar.valid", 32'(hi_if.valid), 32'd0);
    check("ar.code", 32'(hi_if.code), 32'd0);
    check("ar.pend", 32'(hi_if.pend), 32'h00);
    check_model("ar");
    @(negedge clk) rst = 1'b0;
    step("ar_req01", 8'h01, 1'b0, 1'b0);
    check("ar_req01.code", 32'(hi_if.code), 32'd0);
    check("ar_req01.valid", 32'(hi_if.valid), 32'd1);
    step("ar_drain", 8'h00, 1'b1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step("rand", r, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
